// File: rtl/crc32_x64.sv
// Streaming reflected CRC-32 (Ethernet/zlib) over 64-bit words, one word per clock.
// Data, valid and init are forwarded with one cycle of latency; crc is aligned with data_out.
module crc32_x64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        valid_in,
    input  logic        init_in,
    input  logic [63:0] data_in,
    output logic        valid_out,
    output logic        init_out,
    output logic [63:0] data_out,
    output logic [31:0] crc
);

    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY = 32'hEDB8_8320;

    // Strobe semantics: valid_in qualifies data_in for one enabled cycle; there is no
    // back-pressure, so every enabled cycle with valid_in=1 absorbs exactly one word.

    // Bit-serial definition unrolled over the 64 bits; synthesis flattens it to an XOR matrix.
    // Bit order is data[0] first, which is byte 0 LSB-first, then byte 1, and so on.
    function automatic logic [31:0] crc_step64(input logic [31:0] c_in, input logic [63:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]} ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    logic [31:0] s_q, s_d;
    logic [31:0] base;
    logic        valid_q;
    logic        init_q;
    logic [63:0] data_q;

    always_comb begin
        base = init_in ? SEED : s_q;
        s_d  = s_q;
        if (valid_in) begin
            s_d = crc_step64(base, data_in);
        end else if (init_in) begin
            s_d = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= SEED;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
            data_q  <= 64'h0;
        end else if (ce) begin
            s_q     <= s_d;
            valid_q <= valid_in;
            init_q  <= init_in;
            data_q  <= data_in;
        end
    end

    assign valid_out = valid_q;
    assign init_out  = init_q;
    assign data_out  = data_q;
    assign crc       = ~s_q;

endmodule

// File: tb/tb_crc32_x64.sv
// Randomized and directed bench for crc32_x64; the reference recomputes a table-driven
// byte-wise crc32 over the whole current message for every expected value.
module tb_crc32_x64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        valid_in;
    logic        init_in;
    logic [63:0] data_in;
    logic        valid_out;
    logic        init_out;
    logic [63:0] data_out;
    logic [31:0] crc;

    crc32_x64 dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .valid_in  (valid_in),
        .init_in   (init_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .init_out  (init_out),
        .data_out  (data_out),
        .crc       (crc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tab [256];
    logic [7:0]  msg_q [$];
    logic [31:0] exp_q [$];
    logic [63:0] exp_data_q [$];

    logic        ev;
    logic        ei;
    logic [63:0] ed;
    logic        fresh = 1'b0;

    function automatic void build_table();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            tab[n] = c;
        end
    endfunction

    // Standard zlib crc32 of the bytes collected for the current message.
    function automatic logic [31:0] crc32_msg();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (msg_q[j]) begin
            c = tab[(c ^ {24'h0, msg_q[j]}) & 32'hFF] ^ (c >> 8);
        end
        return ~c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid_out"}, {63'h0, valid_out}, {63'h0, ev});
        check({tag, ".init_out"}, {63'h0, init_out}, {63'h0, ei});
        check({tag, ".data_out"}, data_out, ed);
        check({tag, ".crc"}, {32'h0, crc}, {32'h0, crc32_msg()});
    endtask

    // Driver: applies one cycle of inputs, then advances the reference at the same edge.
    task automatic step(input logic r, input logic c, input logic v, input logic i,
                        input logic [63:0] d);
        rst = r; ce = c; valid_in = v; init_in = i; data_in = d;
        @(posedge clk);
        if (r) begin
            msg_q.delete();
            ev = 1'b0; ei = 1'b0; ed = 64'h0;
        end else if (c) begin
            ev = v; ei = i; ed = d;
            if (i) msg_q.delete();
            if (v) begin
                for (int b = 0; b < 8; b++) msg_q.push_back(d[8*b +: 8]);
                exp_q.push_back(crc32_msg());
                exp_data_q.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: a fresh output word appears only after an enabled, non-reset edge.
    always @(posedge clk) fresh <= ce && !rst;

    always @(negedge clk) begin
        if (fresh && valid_out) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon.unexpected: got crc %h expected no word", crc);
            end else begin
                check("mon.crc", {32'h0, crc}, {32'h0, exp_q.pop_front()});
                check("mon.data", data_out, exp_data_q.pop_front());
            end
        end
    end

    logic [63:0] w0, w1, w2;

    initial begin
        build_table();
        rst = 1'b1; ce = 1'b0; valid_in = 1'b0; init_in = 1'b0; data_in = 64'h0;
        ev = 1'b0; ei = 1'b0; ed = 64'h0;
        @(negedge clk);

        // Reset and idle stability
        step(1, 0, 0, 0, 64'h0);
        step(1, 1, 0, 0, 64'h0);
        check_all("reset");
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 64'h0);
            check_all("idle");
        end

        // Known single-word vectors
        step(0, 1, 1, 1, 64'h3837363534333231);
        check_all("ascii");
        check("ascii.known", {32'h0, crc}, {32'h0, 32'h9AE0DAAF});
        step(0, 1, 1, 1, 64'h0);
        check_all("zero");
        check("zero.known", {32'h0, crc}, {32'h0, 32'h6522DF69});

        // Empty message restart
        step(0, 1, 0, 1, rnd64());
        check_all("empty");

        // Multi-word message with gaps and clock-enable stalls
        w0 = rnd64(); w1 = rnd64(); w2 = rnd64();
        step(0, 1, 1, 1, w0);
        check_all("mw.w0");
        step(0, 1, 0, 0, rnd64());
        check_all("mw.gap");
        step(0, 0, 1, 1, rnd64());
        check_all("mw.stall");
        step(0, 1, 1, 0, w1);
        check_all("mw.w1");
        step(0, 0, 0, 1, rnd64());
        check_all("mw.stall2");
        step(0, 1, 1, 0, w2);
        check_all("mw.w2");
        check("mw.len", 64'(msg_q.size()), 64'd24);

        // Back-to-back messages
        step(0, 1, 1, 1, rnd64());
        step(0, 1, 1, 0, rnd64());
        check_all("b2b.a_last");
        step(0, 1, 1, 1, rnd64());
        check_all("b2b.b_first");
        step(0, 1, 1, 0, rnd64());
        check_all("b2b.b_last");

        // Reset mid-message with ce low and valid high
        step(0, 1, 1, 1, rnd64());
        step(1, 0, 1, 0, rnd64());
        check_all("midrst");
        step(0, 1, 1, 1, 64'h3837363534333231);
        check_all("postrst");
        check("postrst.known", {32'h0, crc}, {32'h0, 32'h9AE0DAAF});

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), rnd64());
            check_all("rand");
        end

        step(0, 1, 0, 0, 64'h0);
        check("sb.drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_x64.md
Name: crc32_x64

Overview:
- Streaming CRC-32 (IEEE 802.3 / Ethernet) generator that absorbs one 64-bit word per clock.
- Forwards the data word, valid and init flags with a fixed one-cycle latency.
- Presents alongside them the running CRC of the message up to and including that word.
- Sits in the packet datapath, where downstream logic samples crc on the last word of a message.

Parameters:
- None. Polynomial, seed and word width are fixed.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- ce  input  1  clock enable; when low, every register holds
- valid_in  input  1  data_in carries a word to absorb this cycle
- init_in  input  1  this cycle starts a new message
- data_in  input  64  data word; byte 0 = data_in[7:0] is first on the wire
- valid_out  output  1  valid_in delayed 1 cycle
- init_out  output  1  init_in delayed 1 cycle
- data_out  output  64  data_in delayed 1 cycle
- crc  output  32  running CRC aligned with data_out

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising clk edge.
- CRC definition:
  - Reflected CRC-32, polynomial 0x04C11DB7 (reflected form 0xEDB88320).
  - Seed 0xFFFFFFFF; final XOR 0xFFFFFFFF.
  - Each byte is processed LSB first, bytes in order data_in[7:0] .. data_in[63:56].
  - A message of whole words equals the standard zlib/Ethernet crc32 of its byte string.
- Internal state S (32 bits) holds the un-inverted running remainder. Output crc = ~S, purely combinational from S; no extra register.
- Update per rising edge when rst=0 and ce=1 (base = seed if init_in=1, else S):
  - valid_in=1: S <= F(base, data_in), where F is the 64-bit parallel CRC update (XOR matrix, single cycle).
  - valid_in=0, init_in=1: S <= seed, so crc reads 0x00000000, the empty-message CRC.
  - valid_in=0, init_in=0: S holds.
- Pipeline outputs on the same edge (rst=0, ce=1): valid_out <= valid_in; init_out <= init_in; data_out <= data_in.
  - data_out updates every enabled cycle regardless of valid_in.
- Latency: exactly 1 cycle. On the cycle where valid_out=1, crc includes data_out.
- ce=0: S and all outputs hold; inputs that cycle are ignored (not absorbed, not forwarded).
- rst=1 (overrides ce):
  - S <= 0xFFFFFFFF, so crc = 0x00000000.
  - valid_out=0, init_out=0, data_out=0.
  - Reset mid-message discards the partial CRC.
  - A message after reset must still assert init_in on its first word; S after reset equals the seed, so omitting it yields the same result.
- Back-to-back messages: init_in=1 on a word immediately after a message's last word restarts from seed with no bubble.
  - The previous message's final crc is visible for exactly the one cycle it is aligned with its last data_out.
- No partial-word (byte-enable) support; messages are whole 64-bit words.

Test Plan:
- Reset, then idle with valid_in=0, init_in=0 -> valid_out=0, init_out=0, data_out=0, crc=0x00000000, stable.
- Single-word message: init_in=1, valid_in=1, data_in=64'h3837363534333231 ("12345678") -> next cycle valid_out=1, init_out=1, data_out echoes input, crc=0x9AE0DAAF.
- Single-word message: init_in=1, valid_in=1, data_in=0 -> next cycle crc=0x6522DF69.
- Multi-word message with gaps and ce:
  - Stimulus: words W0 (init), W1, W2, with valid_in=0 cycles and ce=0 cycles interleaved.
  - Required: final crc equals a software crc32 over the 24-byte string.
  - Required: crc holds across gaps; outputs freeze while ce=0.
- Back-to-back messages:
  - Stimulus: message A's last word, then message B's first word with init_in=1 on the very next cycle.
  - Required: A's crc is correct for one cycle, then B's crc equals crc32 of B alone.
- Reset mid-message: rst=1 for one cycle with ce=0 and valid_in=1 -> outputs cleared, crc=0x00000000. Then a new message with init_in=1 yields the correct CRC.
